// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with status flags and a valid/ready
// handshake; LEVELS_PER_STAGE prefix levels are evaluated between registers.
module ks_adder_pipe #(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int L = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int S = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  // Handshake: a transfer happens on any edge where valid && ready. The whole
  // pipeline freezes while a result is presented but not taken, so in_ready is
  // simply the inverse of that stall condition.
  logic w_stall;
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  logic [WIDTH-1:0] r_g    [0:S];
  logic [WIDTH-1:0] r_p    [0:S];
  logic [WIDTH-1:0] r_po   [0:S];
  logic             r_cin  [0:S];
  logic             r_amsb [0:S];
  logic             r_bmsb [0:S];
  logic             r_v    [0:S];

  logic             r_out_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g0;

  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : cin;
  assign w_p0      = a ^ w_b_eff;
  // The carry-in behaves as the generate of a virtual bit below bit 0; merging
  // it into bit 0 up front lets L levels reach every carry including cout.
  assign w_g0      = (a & w_b_eff) | {{(WIDTH-1){1'b0}}, w_p0[0] & w_cin_eff};

  logic [WIDTH-1:0] w_g_nxt [1:S];
  logic [WIDTH-1:0] w_p_nxt [1:S];

  always_comb begin
    logic [WIDTH-1:0] w_cur_g, w_cur_p, w_new_g, w_new_p;
    int               w_lv;
    int               w_span;
    w_g_nxt = '{default: '0};
    w_p_nxt = '{default: '0};
    for (int k = 1; k <= S; k++) begin
      w_cur_g = r_g[k-1];
      w_cur_p = r_p[k-1];
      for (int j = 0; j < LEVELS_PER_STAGE; j++) begin
        w_lv = (k - 1) * LEVELS_PER_STAGE + j;
        if (w_lv < L) begin
          w_span  = 1 << w_lv;
          w_new_g = w_cur_g;
          w_new_p = w_cur_p;
          for (int i = 0; i < WIDTH; i++) begin
            if (i >= w_span) begin
              w_new_g[i] = w_cur_g[i] | (w_cur_p[i] & w_cur_g[i - w_span]);
              w_new_p[i] = w_cur_p[i] & w_cur_p[i - w_span];
            end
          end
          w_cur_g = w_new_g;
          w_cur_p = w_new_p;
        end
      end
      w_g_nxt[k] = w_cur_g;
      w_p_nxt[k] = w_cur_p;
    end
  end

  // After the last stage r_g[S][i] is the carry out of bit i.
  logic [WIDTH-1:0] w_s;
  assign w_s = r_po[S] ^ {r_g[S][WIDTH-2:0], r_cin[S]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= S; k++) begin
        r_v[k]    <= 1'b0;
        r_g[k]    <= '0;
        r_p[k]    <= '0;
        r_po[k]   <= '0;
        r_cin[k]  <= 1'b0;
        r_amsb[k] <= 1'b0;
        r_bmsb[k] <= 1'b0;
      end
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (!w_stall) begin
      r_v[0]    <= in_valid;
      r_g[0]    <= w_g0;
      r_p[0]    <= w_p0;
      r_po[0]   <= w_p0;
      r_cin[0]  <= w_cin_eff;
      r_amsb[0] <= a[WIDTH-1];
      r_bmsb[0] <= w_b_eff[WIDTH-1];
      for (int k = 1; k <= S; k++) begin
        r_v[k]    <= r_v[k-1];
        r_g[k]    <= w_g_nxt[k];
        r_p[k]    <= w_p_nxt[k];
        r_po[k]   <= r_po[k-1];
        r_cin[k]  <= r_cin[k-1];
        r_amsb[k] <= r_amsb[k-1];
        r_bmsb[k] <= r_bmsb[k-1];
      end
      r_out_valid <= r_v[S];
      r_s         <= w_s;
      r_cout      <= r_g[S][WIDTH-1];
      r_ovf       <= (r_amsb[S] == r_bmsb[S]) && (w_s[WIDTH-1] != r_amsb[S]);
      r_zero      <= (w_s == '0);
    end
  end

  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: one instance per width/depth configuration, each with
// an arithmetic reference model, an expected-result queue and a compare process.
module tb_ks_adder_pipe;
  localparam int NCFG = 8;
  localparam int CFG_W   [0:NCFG-1] = '{32, 32, 8, 8, 13, 13, 64, 64};
  localparam int CFG_LPS [0:NCFG-1] = '{2,  1,  1, 3, 1,  4,  1,  6};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int ci, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cfg=%0d actual=%0h required=%0h", nm, ci, act, exp);
    end
  endtask

  for (genvar ci = 0; ci < NCFG; ci++) begin : g_cfg
    localparam int W   = CFG_W[ci];
    localparam int LPS = CFG_LPS[ci];
    localparam int L   = $clog2(W);
    localparam int S   = (L + LPS - 1) / LPS;
    localparam int LAT = S + 1;

    logic         rst, in_valid, in_ready, cin, sub;
    logic         out_valid, out_ready, cout, ovf, zero;
    logic [W-1:0] a, b, s;

    ks_adder_pipe #(.WIDTH(W), .LEVELS_PER_STAGE(LPS)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    // Scoreboard: expected {ovf, zero, cout, s} and the accept edge of each op.
    logic [W+2:0] exp_q[$];
    int           acc_q[$];
    logic [W+2:0] held;
    logic         prev_stall = 1'b0;
    int           last_stall = -1;
    int           stall_req  = 0;
    logic         bp_rand    = 1'b0;

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic logic [W+2:0] model(input logic [W-1:0] ma, mb,
                                           input logic mcin, msub);
      logic [W:0]          u;
      logic signed [W+1:0] t;
      logic [W-1:0]        rs;
      logic                rc, rov;
      if (msub) begin
        rs = ma - mb;
        rc = (ma >= mb);
        t  = $signed({ma[W-1], ma[W-1], ma}) - $signed({mb[W-1], mb[W-1], mb});
      end else begin
        u  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
        rs = u[W-1:0];
        rc = u[W];
        t  = $signed({ma[W-1], ma[W-1], ma}) + $signed({mb[W-1], mb[W-1], mb})
           + $signed({{(W+1){1'b0}}, mcin});
      end
      rov = (t != $signed({rs[W-1], rs[W-1], rs}));
      return {rov, (rs == '0), rc, rs};
    endfunction

    function automatic logic [W-1:0] rand_w();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0:       return '0;
        1:       return '1;
        2:       return {1'b0, {(W-1){1'b1}}};
        3:       return {1'b1, {(W-1){1'b0}}};
        default: return r[W-1:0];
      endcase
    endfunction

    // Driver tasks run from one edge+1 point to the next.
    task automatic idle(input int n);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    endtask

    task automatic send(input logic [W-1:0] ta, tb2, input logic tc, ts);
      logic got;
      int   t;
      got = 1'b0;
      t   = 0;
      a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1;
      while (!got && t < 200) begin
        @(negedge clk);
        got = in_ready;
        t++;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      if (!got) check("send_timeout", ci, 128'(got), 128'(1));
    endtask

    task automatic run_random(input int n, input logic rnd_bp);
      bp_rand = rnd_bp;
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        send(rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      bp_rand = 1'b0;
    endtask

    task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
        idle(1);
        t++;
      end
      if (exp_q.size() != 0) check("drain_timeout", ci, 128'(exp_q.size()), 128'(0));
      idle(3);
    endtask

    task automatic reset_and_check();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      exp_q.delete();
      acc_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", ci, 128'(out_valid), 128'(0));
      check("rst_in_ready", ci, 128'(in_ready), 128'(1));
      check("rst_outputs", ci, 128'({ovf, zero, cout, s}), 128'(0));
      idle(1);
    endtask

    // Sink: out_ready is high unless a scripted stall or random backpressure applies.
    always begin
      @(posedge clk);
      #1;
      if (stall_req > 0) begin
        out_ready = 1'b0;
        stall_req--;
      end else begin
        out_ready = bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end

    // Compare process, sampled mid-cycle.
    always @(negedge clk) begin
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready", ci, 128'(in_ready), 128'(!(out_valid && !out_ready)));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_result", ci, 128'({ovf, zero, cout, s}), 128'(0));
          end else begin
            if (prev_stall) begin
              check("hold", ci, 128'({ovf, zero, cout, s}), 128'(held));
            end else begin
              check("result", ci, 128'({ovf, zero, cout, s}), 128'(exp_q[0]));
              if (last_stall < acc_q[0])
                check("latency", ci, 128'(cyc - acc_q[0]), 128'(LAT));
            end
            if (out_ready) begin
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
            end
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a, b, cin, sub));
          acc_q.push_back(cyc + 1);
        end
        prev_stall = out_valid && !out_ready;
        if (prev_stall) begin
          last_stall = cyc;
          held       = {ovf, zero, cout, s};
        end
      end
    end

    if (ci == 0) begin : g_dir
      localparam logic [31:0] DV_A [0:7] = '{32'h89ABCDEF, 32'hDEADBEEF, 32'hFFFFFFFF,
        32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'h00001234};
      localparam logic [31:0] DV_B [0:7] = '{32'h76543210, 32'hCAFEBABE, 32'hFFFFFFFF,
        32'h00000001, 32'h00000000, 32'h00000007, 32'h00000001, 32'h00001234};
      localparam logic [7:0]  DV_C = 8'b1001_0000;
      localparam logic [7:0]  DV_S = 8'b1110_0000;
      // Hand-computed {ovf, zero, cout, s}.
      localparam logic [34:0] DV_R [0:7] = '{35'h0FFFFFFFF, 35'h1A9AC79AD, 35'h1FFFFFFFE,
        35'h480000000, 35'h300000000, 35'h0FFFFFFFE, 35'h57FFFFFFF, 35'h300000000};

      initial begin
        int t;
        reset_and_check();
        for (int k = 0; k < 8; k++)
          check("model_pin", ci, 128'(model(DV_A[k], DV_B[k], DV_C[k], DV_S[k])),
                128'(DV_R[k]));
        for (int k = 0; k < 8; k++) send(DV_A[k], DV_B[k], DV_C[k], DV_S[k]);
        drain();

        // Six ops with a three-cycle stall right after the first result.
        fork
          begin
            for (int k = 0; k < 6; k++) send(rand_w(), rand_w(), 1'b0, 1'($urandom_range(0, 1)));
          end
          begin
            t = 0;
            do begin
              @(negedge clk);
              t++;
            end while (!out_valid && t < 100);
            if (!out_valid) check("first_result_timeout", ci, 128'(out_valid), 128'(1));
            stall_req = 3;
          end
        join
        drain();

        // Reset with three operations in flight.
        for (int k = 0; k < 3; k++) send(rand_w(), rand_w(), 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", ci, 128'(out_valid), 128'(0));
        check("midrst_s", ci, 128'(s), 128'(0));
        idle(LAT + 2);
        send(32'h00000064, 32'h00000036, 1'b0, 1'b0);
        drain();

        run_random(200, 1'b0);
        run_random(200, 1'b1);
        drain();
        n_done++;
      end
    end else begin : g_rnd
      initial begin
        reset_and_check();
        run_random(150, 1'b0);
        run_random(150, 1'b1);
        drain();
        n_done++;
      end
    end
  end

  initial begin
    int t;
    t = 0;
    while (n_done < NCFG && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (n_done < NCFG) check("global_timeout", -1, 128'(n_done), 128'(NCFG));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
